// File: rtl/bp_update_arbiter_pkg.sv
// Shared branch-predictor update types: the update packet layout and the output source tag.
package bp_update_arbiter_pkg;

    localparam int SIZE_PC          = 32;
    localparam int BRANCH_TYPE_LOG  = 2;
    localparam int SIZE_CNT_TBL_LOG = 10;

    localparam int BP_UPD_PKT_SIZE = 2*SIZE_PC + BRANCH_TYPE_LOG + 1 + 2 + SIZE_CNT_TBL_LOG;

    typedef struct packed {
        logic [SIZE_PC-1:0]          pc;
        logic [SIZE_PC-1:0]          npc;
        logic [BRANCH_TYPE_LOG-1:0]  ctrlType;
        logic                        dir;
        logic [1:0]                  counter;
        logic [SIZE_CNT_TBL_LOG-1:0] index;
    } bpUpdPkt;

    typedef enum logic {
        SRC_REQ0 = 1'b0,
        SRC_REQ1 = 1'b1
    } src_e;

endpackage

// File: rtl/bp_update_arbiter_if.sv
// Request, predictor-update and occupancy signals of the update arbiter, bundled with modports.
interface bp_update_arbiter_if
    import bp_update_arbiter_pkg::*;
#(
    parameter int Q0_DEPTH = 4,
    parameter int Q1_DEPTH = 4
);

    logic                        flush_i;
    logic                        req0Valid_i;
    bpUpdPkt                     req0Pkt_i;
    logic                        req0Ready_o;
    logic                        req1Valid_i;
    bpUpdPkt                     req1Pkt_i;
    logic                        req1Ready_o;
    logic                        updateReady_i;
    logic [SIZE_PC-1:0]          updatePC_o;
    logic [SIZE_PC-1:0]          updateNPC_o;
    logic [BRANCH_TYPE_LOG-1:0]  updateCtrlType_o;
    logic                        updateDir_o;
    logic [1:0]                  updateCounter_o;
    logic [SIZE_CNT_TBL_LOG-1:0] updateIndex_o;
    logic                        updateEn_o;
    logic [$clog2(Q0_DEPTH):0]   q0Count_o;
    logic [$clog2(Q1_DEPTH):0]   q1Count_o;

    modport slave (
        input  flush_i, req0Valid_i, req0Pkt_i, req1Valid_i, req1Pkt_i, updateReady_i,
        output req0Ready_o, req1Ready_o, updatePC_o, updateNPC_o, updateCtrlType_o,
               updateDir_o, updateCounter_o, updateIndex_o, updateEn_o, q0Count_o, q1Count_o
    );

    modport master (
        output flush_i, req0Valid_i, req0Pkt_i, req1Valid_i, req1Pkt_i, updateReady_i,
        input  req0Ready_o, req1Ready_o, updatePC_o, updateNPC_o, updateCtrlType_o,
               updateDir_o, updateCounter_o, updateIndex_o, updateEn_o, q0Count_o, q1Count_o
    );

endinterface

// File: rtl/bp_update_queue.sv
// Circular synchronous FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module bp_update_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     enq_i,
    input  logic [WIDTH-1:0]         enq_data_i,
    input  logic                     deq_i,
    output logic [WIDTH-1:0]         deq_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_enq;
    logic             do_deq;

    assign count_o    = wr_ptr - rd_ptr;
    assign full_o     = (count_o == DEPTH_CNT);
    assign empty_o    = (wr_ptr == rd_ptr);
    assign do_enq     = enq_i & ~full_o & ~clear_i;
    assign do_deq     = deq_i & ~empty_o & ~clear_i;
    assign deq_data_o = mem[rd_ptr[AW-1:0]];

    // A clear wins over any enqueue or dequeue in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_deq) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr[AW-1:0]] <= enq_data_i;
    end

endmodule

// File: rtl/bp_update_arbiter.sv
// Arbitrates execute-side (REQ0) and commit-side (REQ1) predictor updates onto one registered update port.
module bp_update_arbiter
    import bp_update_arbiter_pkg::*;
#(
    parameter int Q0_DEPTH     = 4,
    parameter int Q1_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    bp_update_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    bpUpdPkt                 q0_head;
    bpUpdPkt                 q1_head;
    bpUpdPkt                 out_pkt;
    logic                    out_en;
    src_e                    out_src;
    logic [SW-1:0]           starve_cnt;
    logic                    q0_full, q0_empty, q1_full, q1_empty;
    logic [$clog2(Q0_DEPTH):0] q0_count;
    logic [$clog2(Q1_DEPTH):0] q1_count;
    logic                    load;
    logic                    grant0;
    logic                    grant1;

    assign bus.req0Ready_o = reset & ~q0_full;
    assign bus.req1Ready_o = reset & ~q1_full;
    assign load            = ~out_en | bus.updateReady_i;

    bp_update_queue #(.DEPTH(Q0_DEPTH), .WIDTH(BP_UPD_PKT_SIZE)) u_q0 (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (bus.flush_i),
        .enq_i      (bus.req0Valid_i & bus.req0Ready_o),
        .enq_data_i (bus.req0Pkt_i),
        .deq_i      (grant0),
        .deq_data_o (q0_head),
        .full_o     (q0_full),
        .empty_o    (q0_empty),
        .count_o    (q0_count)
    );

    bp_update_queue #(.DEPTH(Q1_DEPTH), .WIDTH(BP_UPD_PKT_SIZE)) u_q1 (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (1'b0),
        .enq_i      (bus.req1Valid_i & bus.req1Ready_o),
        .enq_data_i (bus.req1Pkt_i),
        .deq_i      (grant1),
        .deq_data_o (q1_head),
        .full_o     (q1_full),
        .empty_o    (q1_empty),
        .count_o    (q1_count)
    );

    // A flushing cycle hides q0 so squashed traffic can never win the port.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (load) begin
            if (starve_cnt == STARVE_MAX && !q1_empty) grant1 = 1'b1;
            else if (!q0_empty && !bus.flush_i)        grant0 = 1'b1;
            else if (!q1_empty)                        grant1 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_pkt <= '0;
            out_en  <= 1'b0;
            out_src <= SRC_REQ0;
        end else if (load) begin
            if (grant1) begin
                out_pkt <= q1_head;
                out_en  <= 1'b1;
                out_src <= SRC_REQ1;
            end else if (grant0) begin
                out_pkt <= q0_head;
                out_en  <= 1'b1;
                out_src <= SRC_REQ0;
            end else begin
                out_en  <= 1'b0;
            end
        end else if (bus.flush_i && out_src == SRC_REQ0) begin
            out_en <= 1'b0;
        end
    end

    // REQ0 grants only happen on loads, so the counter naturally holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (q1_empty || grant1) begin
            starve_cnt <= '0;
        end else if (grant0 && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + STARVE_ONE;
        end
    end

    assign bus.updatePC_o       = out_pkt.pc;
    assign bus.updateNPC_o      = out_pkt.npc;
    assign bus.updateCtrlType_o = out_pkt.ctrlType;
    assign bus.updateDir_o      = out_pkt.dir;
    assign bus.updateCounter_o  = out_pkt.counter;
    assign bus.updateIndex_o    = out_pkt.index;
    assign bus.updateEn_o       = out_en;
    assign bus.q0Count_o        = q0_count;
    assign bus.q1Count_o        = q1_count;

endmodule
